// File: rtl/rr_op_scheduler.sv
// Four-source scheduler sharing one opcode/operand execution unit.
// Arbitration is round-robin or fixed-priority; the result is held under a valid/ready handshake.
module rr_op_scheduler #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] src_valid,
    input  logic [5:0] src_data_0,
    input  logic [5:0] src_data_1,
    input  logic [5:0] src_data_2,
    input  logic [5:0] src_data_3,
    output logic [3:0] src_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] result,
    output logic [1:0] res_src,
    output logic [1:0] res_op,
    output logic       busy,
    output logic [7:0] done_count
);

    localparam int unsigned N_SRC = 4;
    localparam int unsigned PKT_W = 6;
    localparam int unsigned DAT_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             grant_any;
    logic [PKT_W-1:0] grant_pkt;
    logic [DAT_W-1:0] cap_opnd;
    logic [OP_W-1:0]  cap_op;
    logic [IDX_W-1:0] cap_src;
    logic [DAT_W-1:0] alu_out;

    // Winner selection; round-robin scans downward so the nearest index after last_grant wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (FIXED_PRIO) begin
            for (int i = 0; i < int'(N_SRC); i++) begin
                if (src_valid[i]) begin
                    grant_idx = IDX_W'(i);
                    grant_any = 1'b1;
                end
            end
        end else begin
            for (int k = int'(N_SRC); k >= 1; k--) begin
                cand = last_grant + IDX_W'(k);
                if (src_valid[cand]) begin
                    grant_idx = cand;
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    grant_pkt = src_data_0;
            2'd1:    grant_pkt = src_data_1;
            2'd2:    grant_pkt = src_data_2;
            default: grant_pkt = src_data_3;
        endcase
    end

    always_comb begin
        case (cap_op)
            2'b01:   alu_out = cap_opnd & 4'b1010;
            2'b10:   alu_out = cap_opnd + 4'd3;
            2'b11:   alu_out = cap_opnd << 2;
            default: alu_out = '0;
        endcase
    end

    // Next-state and grant strobe; src_ready only ever asserts from IDLE.
    always_comb begin
        state_next = state;
        src_ready  = '0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    src_ready  = N_SRC'(1) << grant_idx;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = (cap_op == 2'b00) ? IDLE : HOLD;
            HOLD: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture, execute and hand-off datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            last_grant <= IDX_W'(3);
            cap_opnd   <= '0;
            cap_op     <= '0;
            cap_src    <= '0;
            result     <= '0;
            res_src    <= '0;
            res_op     <= '0;
            res_valid  <= 1'b0;
            done_count <= '0;
        end else begin
            busy <= (state_next != IDLE);
            if (state == IDLE && grant_any) begin
                last_grant <= grant_idx;
                cap_src    <= grant_idx;
                cap_op     <= grant_pkt[5:4];
                cap_opnd   <= grant_pkt[3:0];
            end
            if (state == EXEC && cap_op != 2'b00) begin
                result    <= alu_out;
                res_src   <= cap_src;
                res_op    <= cap_op;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) begin
                res_valid  <= 1'b0;
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/rr_op_scheduler.md
# rr_op_scheduler

Round-robin scheduler that shares one 6-bit opcode/operand execution unit between four requesting sources. Each source presents a packet (opcode in bits [5:4], operand in bits [3:0]) with a valid/ready handshake. The scheduler grants one source at a time, captures its packet, computes the result, and holds it on a valid/ready output port until the consumer accepts it. It replaces the purely combinational fixed-priority selection path with a fair, registered, flow-controlled one.

## Interface
- FIXED_PRIO, 0: 0 selects round-robin arbitration; 1 selects fixed priority, where source 3 is highest and source 0 is lowest.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- src_valid  input  4  bit i set means source i holds a packet on src_data_i.
- src_data_0 / src_data_1 / src_data_2 / src_data_3  input  6 each  packets: [5:4] opcode, [3:0] operand.
- src_ready  output  4  one-hot or zero. Bit i high means source i's packet is accepted at this clock edge.
- res_valid  output  1  result and its tags are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  4  computed result.
- res_src  output  2  index of the source that produced the result.
- res_op  output  2  opcode that produced the result.
- busy  output  1  high whenever the FSM is not in IDLE.
- done_count  output  8  number of results delivered; wraps from 255 to 0.

## Operation
- FSM states are IDLE, EXEC and HOLD. Reset enters IDLE.
- IDLE:
  - If any src_valid bit is set, choose a winner w, drive src_ready[w]=1 combinationally, capture src_data_w, w and the opcode, then go to EXEC.
  - Otherwise stay in IDLE with src_ready=0.
- Arbitration:
  - Round-robin: search upward from (last_grant+1) mod 4 with wrap-around; the first set bit wins.
  - last_grant updates to w on every grant. Its reset value is 3, so source 0 has first priority after reset.
  - FIXED_PRIO=1: the highest set index wins and last_grant is ignored, though it still updates.
- EXEC computes from the captured operand:
  - 01: operand AND 4'b1010.
  - 10: operand + 3, modulo 16 (carry discarded).
  - 11: operand << 2, truncated to 4 bits.
  - 00: NOP. The packet was consumed, but no result is produced and the FSM returns to IDLE.
  - For opcodes 01/10/11: register result, res_src and res_op, set res_valid=1, and go to HOLD.
- HOLD:
  - result, res_src, res_op and res_valid stay stable until res_ready=1 is sampled high.
  - On that edge: res_valid goes to 0, done_count increments, and the FSM goes to IDLE.
  - src_ready stays 0 in both EXEC and HOLD.
- Source rules:
  - A source must keep src_data stable while its valid is high and not yet accepted.
  - A source may drop valid without being granted; the scheduler takes no action.

## Timing
- Reset values: src_ready=0, res_valid=0, result=0, res_src=0, res_op=0, busy=0, done_count=0, last_grant=3, state=IDLE.
- Packet accepted at edge N (src_ready high in the preceding cycle): EXEC occupies cycle N to N+1, and res_valid is high after edge N+1.
- If res_ready is already high, the result is consumed at edge N+2 and the next grant can occur at edge N+3.
- Peak throughput is one packet per 3 cycles. A NOP costs 2 cycles.
- src_ready is combinational from src_valid, state and last_grant. It has no combinational dependency on res_ready.
- res_ready is ignored outside HOLD.
- Reset asserted mid-operation: return to IDLE immediately, discard any captured or held packet, and clear res_valid. The packet counts as accepted if its src_ready edge had already occurred.
- All four sources valid continuously in round-robin mode: grant order 0,1,2,3,0,…; no source waits more than 3 other grants.

## Test plan
- Single request: after reset, src_valid=0100, src_data_2=6'b10_1110, res_ready=1 -> src_ready=0100 for one cycle, then result=4'b0001, res_src=2, res_op=2'b10, one cycle after capture; done_count=1.
- Round-robin fairness: all four valid, packets 01_1111, 01_0101, 11_0011, 10_0000 on sources 0–3, res_ready=1 -> results 1010, 0000, 1100, 0011 with res_src 0,1,2,3, then 0 again.
- Backpressure: res_ready=0 for 5 cycles in HOLD -> result and tags stable, res_valid high, src_ready=0 throughout, done_count unchanged; res_ready=1 -> one increment.
- NOP: src_data_1=6'b00_1111 valid -> src_ready[1] pulses, res_valid never rises, FSM back in IDLE after 2 cycles, done_count unchanged, last_grant=1.
- FIXED_PRIO=1: sources 0 and 3 continuously valid -> source 3 is always granted.
- Reset in HOLD: rst_n low with res_valid=1 -> res_valid=0, busy=0, done_count=0 asynchronously; the next grant goes to source 0.
